// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: sync/debounce sw8, capture sws as X1 then Y1 with valid/ack handshake (ports: clk, reset, sw8, sws, ack -> data_out, data_valid, data_idx, sw8_db, phase)
module switch_input_ctrl #(
  parameter int n = 8,
  parameter int DB_CYCLES = 16,
  parameter int CW = $clog2(DB_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw8,
  input  logic [n-1:0] sws,
  input  logic         ack,
  output logic [n-1:0] data_out,
  output logic         data_valid,
  output logic         data_idx,
  output logic         sw8_db,
  output logic [2:0]   phase
);
  typedef enum logic [2:0] {WAIT_X = 3'd0, HOLD_X = 3'd1, WAIT_Y = 3'd2, HOLD_Y = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic sw8_m_q, sw8_s_q, db_q, db_d, db_prev_q, press;
  logic [n-1:0] sws_m_q, sws_s_q, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, idx_q, idx_d;
  wire differ = sw8_s_q != db_q;
  wire expire = cnt_q == CW'(DB_CYCLES - 1);
  always_comb begin
    cnt_d = (differ && !expire) ? cnt_q + CW'(1) : '0;
    db_d  = (differ && expire) ? sw8_s_q : db_q;
  end
  // db_prev_q trails db_q by a cycle so press lasts exactly one cycle
  assign press = db_q & ~db_prev_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    case (state_q)
      WAIT_X: if (press) begin
        data_d = sws_s_q; idx_d = 1'b0; valid_d = 1'b1; state_d = HOLD_X;
      end
      HOLD_X: if (ack) begin
        valid_d = 1'b0; state_d = WAIT_Y;
      end
      WAIT_Y: if (press) begin
        data_d = sws_s_q; idx_d = 1'b1; valid_d = 1'b1; state_d = HOLD_Y;
      end
      HOLD_Y: if (ack) begin
        valid_d = 1'b0; state_d = DONE;
      end
      DONE: state_d = press ? WAIT_X : DONE;
      default: state_d = WAIT_X;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sw8_m_q   <= 1'b0;
      sw8_s_q   <= 1'b0;
      sws_m_q   <= '0;
      sws_s_q   <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      state_q   <= WAIT_X;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 1'b0;
    end else begin
      sw8_m_q   <= sw8;
      sw8_s_q   <= sw8_m_q;
      sws_m_q   <= sws;
      sws_s_q   <= sws_m_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_idx   = idx_q;
  assign sw8_db     = db_q;
  assign phase      = state_q;
endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb_switch_input_ctrl: directed self-checking bench for switch_input_ctrl with DB_CYCLES=4
module tb_switch_input_ctrl;
  logic clk = 1'b0, reset = 1'b1, sw8 = 1'b0, ack = 1'b0;
  logic [7:0] sws = '0, data_out;
  logic data_valid, data_idx, sw8_db, db_seen;
  logic [2:0] phase;
  int n_cmp = 0, n_err = 0;
  switch_input_ctrl #(.n(8), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw8(sw8), .sws(sws), .ack(ack),
    .data_out(data_out), .data_valid(data_valid), .data_idx(data_idx),
    .sw8_db(sw8_db), .phase(phase)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (sw8_db === 1'b1) db_seen <= 1'b1;
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  // releases sw8 long enough for the debounced level to fall, then presses;
  // press pulse lands 6 cycles after the raw edge, the FSM reacts on the 7th
  task automatic release_press(input logic [7:0] v);
    sw8 = 1'b0;
    step(8);
    sws = v;
    sw8 = 1'b1;
    step(7);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    step(2);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data got %h exp 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", data_valid); end
    n_cmp++; if (data_idx !== 1'b0) begin n_err++; $display("FAIL rst_idx got %b exp 0", data_idx); end
    n_cmp++; if (sw8_db !== 1'b0) begin n_err++; $display("FAIL rst_db got %b exp 0", sw8_db); end
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL rst_phase got %0d exp 0", phase); end
    reset = 1'b0;
    step(1);
  endtask
  task automatic test_bounce;
    sws = 8'h2A;
    db_seen = 1'b0;
    sw8 = 1'b1; step(3);
    sw8 = 1'b0; step(1);
    sw8 = 1'b1; step(2);
    sw8 = 1'b0; step(10);
    n_cmp++; if (db_seen !== 1'b0) begin n_err++; $display("FAIL bounce_db_seen got %b exp 0", db_seen); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid got %b exp 0", data_valid); end
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL bounce_phase got %0d exp 0", phase); end
  endtask
  task automatic test_x_capture;
    sw8 = 1'b1;
    step(5);
    n_cmp++; if (sw8_db !== 1'b0) begin n_err++; $display("FAIL x_db_early got %b exp 0", sw8_db); end
    step(1);
    n_cmp++; if (sw8_db !== 1'b1) begin n_err++; $display("FAIL x_db_rise got %b exp 1", sw8_db); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL x_valid_early got %b exp 0", data_valid); end
    step(1);
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL x_valid got %b exp 1", data_valid); end
    n_cmp++; if (data_out !== 8'h2A) begin n_err++; $display("FAIL x_data got %h exp 2a", data_out); end
    n_cmp++; if (data_idx !== 1'b0) begin n_err++; $display("FAIL x_idx got %b exp 0", data_idx); end
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL x_phase got %0d exp 1", phase); end
    sws = 8'hFF;
    step(10);
    n_cmp++; if (data_out !== 8'h2A) begin n_err++; $display("FAIL x_hold_data got %h exp 2a", data_out); end
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL x_hold_valid got %b exp 1", data_valid); end
  endtask
  task automatic test_y_capture;
    ack = 1'b1; step(1); ack = 1'b0;
    n_cmp++; if (phase !== 3'd2) begin n_err++; $display("FAIL y_ack_phase got %0d exp 2", phase); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL y_ack_valid got %b exp 0", data_valid); end
    ack = 1'b1; step(2); ack = 1'b0;
    n_cmp++; if (phase !== 3'd2) begin n_err++; $display("FAIL y_stray_ack_phase got %0d exp 2", phase); end
    release_press(8'hF3);
    n_cmp++; if (data_out !== 8'hF3) begin n_err++; $display("FAIL y_data got %h exp f3", data_out); end
    n_cmp++; if (data_idx !== 1'b1) begin n_err++; $display("FAIL y_idx got %b exp 1", data_idx); end
    n_cmp++; if (phase !== 3'd3) begin n_err++; $display("FAIL y_phase got %0d exp 3", phase); end
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL y_valid got %b exp 1", data_valid); end
    ack = 1'b1; step(1); ack = 1'b0;
    n_cmp++; if (phase !== 3'd4) begin n_err++; $display("FAIL y_done_phase got %0d exp 4", phase); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL y_done_valid got %b exp 0", data_valid); end
  endtask
  task automatic test_done_press;
    release_press(8'h77);
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL done_phase got %0d exp 0", phase); end
    n_cmp++; if (data_out !== 8'hF3) begin n_err++; $display("FAIL done_data got %h exp f3", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL done_valid got %b exp 0", data_valid); end
  endtask
  task automatic test_hold_press;
    release_press(8'h11);
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL hp_x_phase got %0d exp 1", phase); end
    release_press(8'h99);
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL hp_ignored_phase got %0d exp 1", phase); end
    n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL hp_ignored_data got %h exp 11", data_out); end
    ack = 1'b1; step(1); ack = 1'b0;
    step(10);
    n_cmp++; if (phase !== 3'd2) begin n_err++; $display("FAIL hp_no_queue_phase got %0d exp 2", phase); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL hp_no_queue_valid got %b exp 0", data_valid); end
  endtask
  task automatic test_press_ack_same;
    release_press(8'h22);
    n_cmp++; if (phase !== 3'd3) begin n_err++; $display("FAIL pa_hold_phase got %0d exp 3", phase); end
    sw8 = 1'b0; step(8);
    sw8 = 1'b1; step(6);
    n_cmp++; if (sw8_db !== 1'b1) begin n_err++; $display("FAIL pa_db got %b exp 1", sw8_db); end
    ack = 1'b1; step(1); ack = 1'b0;
    n_cmp++; if (phase !== 3'd4) begin n_err++; $display("FAIL pa_phase got %0d exp 4", phase); end
    step(5);
    n_cmp++; if (phase !== 3'd4) begin n_err++; $display("FAIL pa_dropped_phase got %0d exp 4", phase); end
    n_cmp++; if (data_out !== 8'h22) begin n_err++; $display("FAIL pa_data got %h exp 22", data_out); end
  endtask
  task automatic test_reset_mid;
    release_press(8'h00);
    release_press(8'h5A);
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid got %b exp 1", data_valid); end
    reset = 1'b1; step(1); reset = 1'b0;
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b exp 0", data_valid); end
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL rm_phase got %0d exp 0", phase); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rm_data got %h exp 00", data_out); end
    release_press(8'h3C);
    n_cmp++; if (data_idx !== 1'b0) begin n_err++; $display("FAIL rm_idx got %b exp 0", data_idx); end
    n_cmp++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL rm_cap_data got %h exp 3c", data_out); end
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL rm_cap_phase got %0d exp 1", phase); end
  endtask
  initial begin
    test_reset;
    test_bounce;
    test_x_capture;
    test_y_capture;
    test_done_press;
    test_hold_press;
    test_press_ack_same;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
